mips_control_fsm: RTL
=====================

# mips_control_fsm

Multicycle main control unit for the MIPS core. It sequences every instruction through fetch, decode, execute, memory and writeback states, and drives the datapath strobes. These include the instruction register's `IRWrite` and `IR_sel`. The block consumes the `op`/`func` fields the instruction register produces and sits directly downstream of it, closing the fetch loop back into it.

## Interface
Parameters: none.
- `clk`  in  1  sole clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high reset
- `op`  in  6  opcode field from instruction register
- `func`  in  6  function field from instruction register; used only for illegal-R detection
- `mem_waitrequest`  in  1  memory not ready; present only with `MIPS_MEM_WAIT_EN`
- `IRWrite`, `IR_sel`  out  1  instruction register load / pass-through select
- `PCWrite`, `PCWriteCond`, `BranchNE`  out  1  unconditional PC load / branch-gated load / invert zero for bne
- `IorD`, `MemRead`, `MemWrite`  out  1  address select (1=ALUOut) / memory strobes
- `RegWrite`  out  1  register file write
- `RegDst`, `MemtoReg`  out  2  dest 00 rt, 01 rd, 10 $31 / data 00 ALUOut, 01 MDR, 10 PC
- `ALUSrcA`  out  1  0=PC, 1=A
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
- `ALUOp`  out  2  00 add, 01 sub, 10 by func, 11 by op
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `illegal_instr`  out  1  one-cycle pulse on unsupported opcode/func
- `state_dbg`  out  4  current state encoding

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP.
- Outputs are Moore, decoded from the state. Exception: in FETCH, MEM_READ and MEM_WRITE, `IRWrite`, `PCWrite`, `MemWrite` are also qualified by memory acceptance.
- FETCH: `MemRead`, `IorD`=0, `IR_sel`=1, `IRWrite`, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00, `PCWrite` → DECODE.
- DECODE (`IR_sel`=0): `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target to ALUOut). Dispatch by op:
  - 0x23 lw, 0x2B sw → MEM_ADDR
  - 0x00 → EXEC_R
  - 0x09/0x0C/0x0D/0x0A → EXEC_I
  - 0x04/0x05 → BRANCH
  - 0x02/0x03 → JUMP
  - else pulse `illegal_instr`, → FETCH
- R-type func outside {0x20,0x21,0x22,0x23,0x24,0x25,0x2A,0x2B,0x00,0x02} is treated as illegal in DECODE.
- MEM_ADDR: A + sext imm → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: `MemRead`, `IorD`=1 → MEM_WB. MEM_WB: `RegWrite`, `RegDst`=00, `MemtoReg`=01 → FETCH.
- MEM_WRITE: `MemWrite`, `IorD`=1 → FETCH.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10 → WB_R. WB_R: `RegWrite`, `RegDst`=01 → FETCH.
- EXEC_I: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=11 → WB_I. WB_I: `RegWrite`, `RegDst`=00 → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`, `PCSource`=01, `BranchNE`=(op==0x05) → FETCH.
- JUMP: `PCWrite`, `PCSource`=10. For jal, also `RegWrite`, `RegDst`=10, `MemtoReg`=10 (PC already holds PC+4) → FETCH.
- Any output not listed for a state is 0.

## Timing
- While `reset`=1, all outputs are forced to 0 combinationally. The posedge with `reset`=1 loads FETCH.
- The first fetch occurs in the cycle after `reset` deasserts.
- Reset mid-instruction abandons the instruction. No write strobes are asserted in the reset cycle.
- Cycle counts (no waits): lw 5, sw 4, R 4, I-ALU 4, beq/bne 3, j/jal 3, illegal 2.
- The instruction register latches on the FETCH exit edge. DECODE sees the registered `op`.

## Configuration
- `MIPS_MEM_WAIT_EN` defined:
  - The `mem_waitrequest` port exists.
  - FETCH, MEM_READ and MEM_WRITE hold while it is 1.
  - `IRWrite`/`PCWrite`/`MemWrite` assert only in the accepting cycle (waitrequest=0). `MemRead` stays high throughout the wait.
- Undefined: the port is absent and memory is single-cycle; timings are as above.

## Structure
- `mips_pkg`: state enum, opcode/func localparams, `RegDst`/`MemtoReg`/`ALUSrcB`/`ALUOp`/`PCSource` encodings.
- Sub-module `mips_ctrl_decode`: combinational state→control-word map. The top-level module holds the state register, the dispatch logic and the handshake qualification.

## Test plan
- Reset held 3 cycles with op=0x23 → all outputs 0; first post-reset cycle shows FETCH with `IRWrite`=`PCWrite`=`IR_sel`=1.
- op=0x23 → FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; `RegWrite`=1, `MemtoReg`=01 only in cycle 5.
- op=0x00, func=0x20 → `RegWrite`, `RegDst`=01 in cycle 4. With func=0x3F → `illegal_instr` pulse in DECODE, then FETCH.
- op=0x05 → BRANCH with `PCWriteCond`=1, `BranchNE`=1, `ALUOp`=01. op=0x03 → JUMP with `RegDst`=10, `MemtoReg`=10, `PCSource`=10.
- `MIPS_MEM_WAIT_EN`, waitrequest=1 for 2 cycles in FETCH → FETCH lasts 3 cycles; `IRWrite` high only in the 3rd.
- `reset` asserted during MEM_WRITE → no `MemWrite` that cycle; FETCH follows.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS main control unit: states, opcode/func
// values, datapath mux encodings and the packed control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10} mem_to_reg_e;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} alu_src_b_e;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNC = 2'b10, ALUOP_OP = 2'b11} alu_op_e;
  typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10} pc_source_e;

  typedef struct packed {
    logic        ir_write;
    logic        ir_sel;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    reg_dst_e    reg_dst;
    mem_to_reg_e mem_to_reg;
    logic        alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
    pc_source_e  pc_source;
  } ctrl_t;

  // Supported R-type functions: add/addu/sub/subu/and/or/slt/sltu/sll/srl.
  function automatic logic func_legal(input logic [5:0] f);
    case (f)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
      6'h25, 6'h2A, 6'h2B, 6'h00, 6'h02: func_legal = 1'b1;
      default:                           func_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control word map (pure Moore decode; only the jump
// and branch states look at the registered opcode).
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    // NOTE: every field gets a default first so no path through the case infers a latch.
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_sel    = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE:   ctrl_o.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNC;
      end
      S_WB_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = REGDST_RD;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_OP;
      end
      S_WB_I:     ctrl_o.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = (op_i == OP_BNE);
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
        // jal links the already-incremented PC into $31.
        if (op_i == OP_JAL) begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = REGDST_RA;
          ctrl_o.mem_to_reg = M2R_PC;
        end
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control: state register, opcode dispatch and memory
// handshake qualification. Define MIPS_MEM_WAIT_EN to add mem_waitrequest stalls.
module mips_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
`ifdef MIPS_MEM_WAIT_EN
  input  logic       mem_waitrequest,
`endif
  output logic       IRWrite,
  output logic       IR_sel,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_qual;
  logic   illegal_d;
  logic   mem_ready;
  logic   mem_state;

`ifdef MIPS_MEM_WAIT_EN
  assign mem_ready = ~mem_waitrequest;
`else
  assign mem_ready = 1'b1;
`endif

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register updates from pre-edge values.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                        state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            if (func_legal(func)) state_d = S_EXEC_R;
            else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
          OP_J, OP_JAL:                        state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_WB_R;
      S_EXEC_I:    state_d = S_WB_I;
      default:     state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state_i (state_q),
    .op_i    (op),
    .ctrl_o  (ctrl)
  );

  // Commit strobes only in the accepting cycle; reset overrides everything.
  always_comb begin
    ctrl_qual = ctrl;
    if (mem_state && !mem_ready) begin
      ctrl_qual.ir_write  = 1'b0;
      ctrl_qual.pc_write  = 1'b0;
      ctrl_qual.mem_write = 1'b0;
    end
    if (reset) ctrl_qual = '0;
  end

  assign IRWrite       = ctrl_qual.ir_write;
  assign IR_sel        = ctrl_qual.ir_sel;
  assign PCWrite       = ctrl_qual.pc_write;
  assign PCWriteCond   = ctrl_qual.pc_write_cond;
  assign BranchNE      = ctrl_qual.branch_ne;
  assign IorD          = ctrl_qual.iord;
  assign MemRead       = ctrl_qual.mem_read;
  assign MemWrite      = ctrl_qual.mem_write;
  assign RegWrite      = ctrl_qual.reg_write;
  assign RegDst        = ctrl_qual.reg_dst;
  assign MemtoReg      = ctrl_qual.mem_to_reg;
  assign ALUSrcA       = ctrl_qual.alu_src_a;
  assign ALUSrcB       = ctrl_qual.alu_src_b;
  assign ALUOp         = ctrl_qual.alu_op;
  assign PCSource      = ctrl_qual.pc_source;
  assign illegal_instr = illegal_d & ~reset;
  assign state_dbg     = reset ? 4'd0 : state_q;

endmodule
